// File: rtl/dma_xfer_seq.sv
// dma_xfer_seq: upstream DMA transfer sequencer. It holds the CPU-programmed
// source address and transfer count, requests the DSP bus, and issues one
// DMA0WRL kick per transfer to the memory-cycle block. It steps address and
// count after each completed cycle, then releases the bus and raises an
// interrupt at terminal count.
// Optional build macro: DMA_XFER_TIMEOUT_EN adds a WCYC watchdog that drives DMAERR.
module dma_xfer_seq #(
  parameter int unsigned AW = 20,
  parameter int unsigned CW = 16
) (
  input  logic          CLK,
  input  logic          RESETL,
  input  logic [7:0]    D,
  input  logic [2:0]    RS,
  input  logic          REGWRL,
  input  logic          DSPBAK,
  input  logic          ST23L,
  output logic          DSPBRQ,
  output logic          DMA0WRL,
  output logic [AW-1:0] DMA_A,
  output logic          DMAACT,
  output logic          DMAIRQ,
  output logic          DMAERR
);

  localparam int unsigned AHW = AW - 16;
  localparam int unsigned CHW = CW - 8;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_KICK, S_WCYC, S_STEP, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_cnt;
  logic            r_dec;
  logic            r_ien;
  logic            r_abort;
  logic            r_st23_q;
  logic            r_seen_low;
  logic            r_dspbrq;
  logic            r_dma0wrl;
  logic            r_dmaact;
  logic            r_dmairq;
  logic            w_reg_wr;
  logic            w_ctrl_wr;
  logic            w_abort;
  logic            w_start;
  logic            w_cyc_done;
  logic            w_timeout;
  logic            w_step;
  logic            w_set_irq;
  logic [CW-1:0]   w_cnt_dec;

  assign w_reg_wr   = !REGWRL;
  assign w_ctrl_wr  = w_reg_wr && (RS == 3'd5);
  assign w_abort    = w_ctrl_wr && D[7];
  assign w_start    = w_ctrl_wr && D[0] && !D[7];
  assign w_cyc_done = r_seen_low && r_st23_q;
  assign w_cnt_dec  = r_cnt - CW'(1);

`ifdef DMA_XFER_TIMEOUT_EN
  logic [7:0] r_tmo;
  logic       r_dmaerr;

  // Watchdog: counts WCYC cycles; cleared whenever the FSM is outside WCYC
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_tmo <= 8'd0;
    end else if (r_state != S_WCYC) begin
      r_tmo <= 8'd0;
    end else if (r_tmo != 8'hFF) begin
      r_tmo <= r_tmo + 8'd1;
    end
  end

  // Trip on the 255th WCYC cycle without a cycle-done edge
  assign w_timeout = (r_state == S_WCYC) && !w_cyc_done && (r_tmo == 8'd254);

  // Sticky error flag; a ctrl write clears it
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_dmaerr <= 1'b0;
    end else if (w_timeout) begin
      r_dmaerr <= 1'b1;
    end else if (w_ctrl_wr) begin
      r_dmaerr <= 1'b0;
    end
  end

  assign DMAERR = r_dmaerr;
`else
  assign w_timeout = 1'b0;
  assign DMAERR    = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_set_irq   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_abort) begin
          w_state_nxt = S_DONE;
        end else if (w_start) begin
          w_state_nxt = (r_cnt == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (w_abort) begin
          w_state_nxt = S_DONE;
        end else if (DSPBAK) begin
          w_state_nxt = S_KICK;
        end
      end
      S_KICK: begin
        w_state_nxt = w_abort ? S_DONE : S_WCYC;
      end
      S_WCYC: begin
        if (w_cyc_done) begin
          w_state_nxt = S_STEP;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STEP: begin
        w_step = 1'b1;
        if ((w_cnt_dec == '0) || r_abort || w_abort) begin
          w_state_nxt = S_DONE;
        end else if (DSPBAK) begin
          w_state_nxt = S_KICK;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DONE: begin
        w_set_irq   = r_ien && !r_abort;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Programmable registers, address/count stepping and abort bookkeeping
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
      r_ien   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      if (w_reg_wr && (r_state == S_IDLE)) begin
        case (RS)
          3'd0: r_addr[7:0]     <= D;
          3'd1: r_addr[15:8]    <= D;
          3'd2: r_addr[AW-1:16] <= D[AHW-1:0];
          3'd3: r_cnt[7:0]      <= D;
          3'd4: r_cnt[CW-1:8]   <= D[CHW-1:0];
          3'd5: begin
            r_dec <= D[1];
            r_ien <= D[2];
          end
          default: ;
        endcase
      end
      if (w_step) begin
        r_addr <= r_dec ? (r_addr - AW'(1)) : (r_addr + AW'(1));
        r_cnt  <= w_cnt_dec;
      end
      if (w_state_nxt == S_IDLE) begin
        r_abort <= 1'b0;
      end else if (w_abort) begin
        r_abort <= 1'b1;
      end
    end
  end

  // Cycle-done detection: registered ST23L must be seen low, then high, in WCYC
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_st23_q   <= 1'b1;
      r_seen_low <= 1'b0;
    end else begin
      r_st23_q <= ST23L;
      if (r_state != S_WCYC) begin
        r_seen_low <= 1'b0;
      end else if (!r_st23_q) begin
        r_seen_low <= 1'b1;
      end
    end
  end

  // Registered outputs decoded from the next state; sticky IRQ
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      r_dspbrq  <= 1'b0;
      r_dma0wrl <= 1'b1;
      r_dmaact  <= 1'b0;
      r_dmairq  <= 1'b0;
    end else begin
      r_dspbrq  <= (w_state_nxt == S_REQ)  || (w_state_nxt == S_KICK) ||
                   (w_state_nxt == S_WCYC) || (w_state_nxt == S_STEP);
      r_dma0wrl <= (w_state_nxt != S_KICK);
      r_dmaact  <= (w_state_nxt != S_IDLE);
      if (w_set_irq) begin
        r_dmairq <= 1'b1;
      end else if (w_ctrl_wr) begin
        r_dmairq <= 1'b0;
      end
    end
  end

  assign DSPBRQ  = r_dspbrq;
  assign DMA0WRL = r_dma0wrl;
  assign DMA_A   = r_addr;
  assign DMAACT  = r_dmaact;
  assign DMAIRQ  = r_dmairq;

endmodule

// File: tb/tb_dma_xfer_seq.sv
// Testbench for dma_xfer_seq: table-driven transfers, hand-written corner
// sequences (zero count, abort, withheld bus grant, async reset), randomized
// transfers against an arithmetic reference model, and the optional
// DMA_XFER_TIMEOUT_EN watchdog when that macro is defined.
module tb_dma_xfer_seq;

  logic        CLK;
  logic        RESETL;
  logic [7:0]  D;
  logic [2:0]  RS;
  logic        REGWRL;
  logic        DSPBAK;
  logic        ST23L;
  logic        DSPBRQ;
  logic        DMA0WRL;
  logic [19:0] DMA_A;
  logic        DMAACT;
  logic        DMAIRQ;
  logic        DMAERR;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;
  int viol   = 0;
  bit mem_en = 0;
  bit bak_rand = 0;

  dma_xfer_seq #(.AW(20), .CW(16)) dut (
    .CLK(CLK), .RESETL(RESETL), .D(D), .RS(RS), .REGWRL(REGWRL),
    .DSPBAK(DSPBAK), .ST23L(ST23L), .DSPBRQ(DSPBRQ), .DMA0WRL(DMA0WRL),
    .DMA_A(DMA_A), .DMAACT(DMAACT), .DMAIRQ(DMAIRQ), .DMAERR(DMAERR)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // Memory-cycle block model: ST23L low for two cycles after each kick
  initial begin
    int lowc;
    lowc = 0;
    ST23L = 1;
    forever begin
      @(negedge CLK);
      if (!mem_en) begin
        ST23L = 1;
        lowc = 0;
      end else begin
        if (DMA0WRL == 1'b0) lowc = 2;
        if (lowc > 0) begin
          ST23L = 0;
          lowc--;
        end else begin
          ST23L = 1;
        end
      end
    end
  end

  // Kick counter and bus-ownership monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (DMA0WRL == 1'b0) begin
        pulses++;
        if (DSPBRQ == 1'b0) viol++;
      end
    end
  end

  // Random bus-grant jitter during the randomized phase
  initial begin
    forever begin
      @(negedge CLK);
      if (bak_rand) DSPBAK = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] rs, input logic [7:0] d);
    @(negedge CLK);
    RS = rs;
    D = d;
    REGWRL = 0;
    @(posedge CLK);
    #1 REGWRL = 1;
  endtask

  task automatic prog(input logic [19:0] a, input logic [15:0] c);
    wr(3'd0, a[7:0]);
    wr(3'd1, a[15:8]);
    wr(3'd2, {4'h0, a[19:16]});
    wr(3'd3, c[7:0]);
    wr(3'd4, c[15:8]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      if (!DMAACT) begin
        ok = 1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      if (pulses >= n) begin
        ok = 1;
        break;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [19:0] base;
    logic [15:0] cnt;
    logic [7:0]  ctrl;
    logic [19:0] exp_a;
    logic        exp_irq;
    int          exp_pulses;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{20'h12345, 16'd3,     8'h05, 20'h12348, 1'b1, 3};
    vt[1] = '{20'h00001, 16'd2,     8'h07, 20'hFFFFF, 1'b1, 2};
    vt[2] = '{20'h00001, 16'd2,     8'h03, 20'hFFFFF, 1'b0, 2};
    vt[3] = '{20'hFFFFF, 16'd1,     8'h05, 20'h00000, 1'b1, 1};
    vt[4] = '{20'hABCDE, 16'd0,     8'h05, 20'hABCDE, 1'b1, 0};
    vt[5] = '{20'h00010, 16'd4,     8'h07, 20'h0000C, 1'b1, 4};
    vt[6] = '{20'h00800, 16'h0102,  8'h01, 20'h00902, 1'b0, 258};

    RESETL = 0; D = 0; RS = 0; REGWRL = 1; DSPBAK = 1;
    #12;
    chk("rst_dspbrq", 32'(DSPBRQ), 32'd0);
    chk("rst_dma0wrl", 32'(DMA0WRL), 32'd1);
    chk("rst_dma_a", 32'(DMA_A), 32'd0);
    chk("rst_dmaact", 32'(DMAACT), 32'd0);
    chk("rst_dmairq", 32'(DMAIRQ), 32'd0);
    chk("rst_dmaerr", 32'(DMAERR), 32'd0);
    @(negedge CLK);
    RESETL = 1;
    mem_en = 1;

    // Zero-count start: DONE then IDLE, IRQ one cycle after the write edge
    prog(20'h00042, 16'd0);
    pulses = 0;
    wr(3'd5, 8'h05);
    chk("zc_act", 32'(DMAACT), 32'd1);
    chk("zc_brq", 32'(DSPBRQ), 32'd0);
    chk("zc_irq_early", 32'(DMAIRQ), 32'd0);
    @(posedge CLK);
    #1;
    chk("zc_irq", 32'(DMAIRQ), 32'd1);
    chk("zc_act_done", 32'(DMAACT), 32'd0);
    chk("zc_pulses", 32'(pulses), 32'd0);
    wr(3'd5, 8'h00);
    chk("irq_clear", 32'(DMAIRQ), 32'd0);

    // Table-driven transfers
    for (int i = 0; i < 7; i++) begin
      prog(vt[i].base, vt[i].cnt);
      pulses = 0;
      wr(3'd5, vt[i].ctrl);
      wait_idle($sformatf("vec%0d_idle", i), 4000);
      chk($sformatf("vec%0d_addr", i), 32'(DMA_A), 32'(vt[i].exp_a));
      chk($sformatf("vec%0d_irq", i), 32'(DMAIRQ), 32'(vt[i].exp_irq));
      chk($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vt[i].exp_pulses));
      chk($sformatf("vec%0d_brq", i), 32'(DSPBRQ), 32'd0);
    end

    // Abort during the second WCYC: in-flight cycle completes, no IRQ
    prog(20'h00100, 16'd5);
    pulses = 0;
    wr(3'd5, 8'h05);
    wait_pulses("abt_wait2", 2, 200);
    wr(3'd5, 8'h80);
    wait_idle("abt_idle", 200);
    chk("abt_addr", 32'(DMA_A), 32'h00102);
    chk("abt_irq", 32'(DMAIRQ), 32'd0);
    chk("abt_act", 32'(DMAACT), 32'd0);
    chk("abt_pulses", 32'(pulses), 32'd2);
    // Restart: the remaining count of 3 must finish; writes while active ignored
    pulses = 0;
    wr(3'd5, 8'h05);
    wr(3'd0, 8'h55);
    wr(3'd5, 8'h01);
    wait_idle("rst_idle", 200);
    chk("rst_addr", 32'(DMA_A), 32'h00105);
    chk("rst_pulses", 32'(pulses), 32'd3);
    chk("rst_irq", 32'(DMAIRQ), 32'd1);

    // Randomized transfers against an arithmetic model
    bak_rand = 1;
    for (int i = 0; i < 10; i++) begin
      logic [19:0] base;
      logic [15:0] cnt;
      logic        dec;
      logic        ien;
      logic [19:0] exp_a;
      int unsigned tmp;
      base = 20'($urandom);
      cnt = 16'($urandom_range(0, 6));
      dec = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      tmp = dec ? (32'(base) + 32'h100000 - 32'(cnt)) : (32'(base) + 32'(cnt));
      exp_a = tmp[19:0];
      prog(base, cnt);
      pulses = 0;
      wr(3'd5, {5'b0, ien, dec, 1'b1});
      wait_idle($sformatf("rnd%0d_idle", i), 1000);
      chk($sformatf("rnd%0d_addr", i), 32'(DMA_A), 32'(exp_a));
      chk($sformatf("rnd%0d_irq", i), 32'(DMAIRQ), 32'(ien));
      chk($sformatf("rnd%0d_pulses", i), 32'(pulses), 32'(cnt));
    end
    bak_rand = 0;
    DSPBAK = 1;

    // Bus grant withheld: request held, no kick until DSPBAK rises
    mem_en = 0;
    DSPBAK = 0;
    prog(20'h00300, 16'd1);
    pulses = 0;
    wr(3'd5, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("bak%0d_brq", i), 32'(DSPBRQ), 32'd1);
      chk($sformatf("bak%0d_wrl", i), 32'(DMA0WRL), 32'd1);
    end
    DSPBAK = 1;
    wait_pulses("bak_kick", 1, 10);
    // Reset asserted mid-WCYC (ST23L held high, so the cycle never finishes)
    repeat (3) @(posedge CLK);
    #3 RESETL = 0;
    #1;
    chk("mid_rst_brq", 32'(DSPBRQ), 32'd0);
    chk("mid_rst_wrl", 32'(DMA0WRL), 32'd1);
    chk("mid_rst_addr", 32'(DMA_A), 32'd0);
    chk("mid_rst_act", 32'(DMAACT), 32'd0);
    chk("mid_rst_irq", 32'(DMAIRQ), 32'd0);
    chk("mid_rst_err", 32'(DMAERR), 32'd0);
    @(negedge CLK);
    RESETL = 1;

`ifdef DMA_XFER_TIMEOUT_EN
    // Watchdog: kick issued, ST23L never goes low
    prog(20'h00200, 16'd2);
    pulses = 0;
    wr(3'd5, 8'h05);
    wait_pulses("tmo_kick", 1, 20);
    begin
      bit seen;
      int waited;
      seen = 0;
      waited = 0;
      for (int i = 0; i < 400; i++) begin
        @(posedge CLK);
        #1;
        waited++;
        if (DMAERR) begin
          seen = 1;
          break;
        end
      end
      chk("tmo_err", 32'(seen), 32'd1);
      chk("tmo_not_early", 32'(waited >= 250), 32'd1);
    end
    chk("tmo_brq", 32'(DSPBRQ), 32'd0);
    chk("tmo_addr", 32'(DMA_A), 32'h00200);
    chk("tmo_irq", 32'(DMAIRQ), 32'd0);
    chk("tmo_pulses", 32'(pulses), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk("tmo_sticky", 32'(DMAERR), 32'd1);
    chk("tmo_idle", 32'(DMAACT), 32'd0);
    wr(3'd5, 8'h00);
    chk("tmo_clear", 32'(DMAERR), 32'd0);
`else
    chk("err_tied", 32'(DMAERR), 32'd0);
`endif

    chk("kick_without_bus", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
